// File: rtl/conv_pkg.sv
// ============================================================================
// conv_pkg -- shared FSM state encoding and default widths for conv_oc_scheduler
// Revision: 1.0
// ============================================================================
`default_nettype none

package conv_pkg;

   localparam int DEF_DATA_WIDTH   = 8;
   localparam int DEF_WEIGHT_WIDTH = 8;
   localparam int DEF_KERNEL_SIZE  = 3;
   localparam int DEF_IN_CHANNEL   = 3;
   localparam int DEF_OUT_CHANNEL  = 4;
   localparam int DEF_OUTPUT_WIDTH = 20;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      MAC   = 2'd2,
      OUT   = 2'd3
   } conv_state_e;

   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/conv_oc_scheduler.sv
// ============================================================================
// conv_oc_scheduler -- applies OUT_CHANNEL weight sets to one latched window via an external MAC
// Optional macro CONV_OC_PERF_CNT_EN adds busy-cycle and result counters. Revision: 1.0
// ============================================================================
`default_nettype none

module conv_oc_scheduler
   import conv_pkg::*;
#(
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
   parameter int KERNEL_SIZE  = DEF_KERNEL_SIZE,
   parameter int IN_CHANNEL   = DEF_IN_CHANNEL,
   parameter int OUT_CHANNEL  = DEF_OUT_CHANNEL,
   parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
   localparam int K    = KERNEL_SIZE * KERNEL_SIZE * IN_CHANNEL,
   localparam int OC_W = clog2_min1(OUT_CHANNEL)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      window_valid,
   output logic                      window_ready,
   input  logic [K*DATA_WIDTH-1:0]   multi_channel_window_in,
   output logic                      wgt_rd_en,
   output logic [OC_W-1:0]           wgt_addr,
   input  logic [K*WEIGHT_WIDTH-1:0] wgt_rd_data,
   output logic [K*DATA_WIDTH-1:0]   mac_window,
   output logic                      mac_window_valid,
   output logic [K*WEIGHT_WIDTH-1:0] mac_weight,
   output logic                      mac_weight_valid,
   input  logic [OUTPUT_WIDTH-1:0]   mac_conv_out,
   input  logic                      mac_conv_valid,
   output logic [OUTPUT_WIDTH-1:0]   result_data,
   output logic [OC_W-1:0]           result_oc,
   output logic                      result_last,
   output logic                      result_valid,
   input  logic                      result_ready
`ifdef CONV_OC_PERF_CNT_EN
   ,
   output logic [31:0]               perf_busy_cycles,
   output logic [31:0]               perf_results
`endif
);

   localparam logic [OC_W-1:0] c_last_oc = OC_W'(OUT_CHANNEL - 1);

   conv_state_e                state_q, state_d;
   logic [OC_W-1:0]            oc_q, oc_d;
   logic [K*DATA_WIDTH-1:0]    window_q, window_d;
   logic [OUTPUT_WIDTH-1:0]    result_q, result_d;
   logic [K*DATA_WIDTH-1:0]    win_hold_q, win_hold_d;
   logic [K*WEIGHT_WIDTH-1:0]  wgt_hold_q, wgt_hold_d;
   logic                       w_is_last;
   logic                       w_out_hs;

   assign w_is_last = (oc_q == c_last_oc);
   assign w_out_hs  = (state_q == OUT) && result_ready;

   always_comb begin
      state_d    = state_q;
      oc_d       = oc_q;
      window_d   = window_q;
      result_d   = result_q;
      win_hold_d = win_hold_q;
      wgt_hold_d = wgt_hold_q;
      case (state_q)
         IDLE: begin
            if (window_valid) begin
               window_d = multi_channel_window_in;
               oc_d     = '0;
               state_d  = FETCH;
            end
         end
         FETCH: state_d = MAC;
         MAC: begin
            // An invalid MAC return is recorded as zero rather than stale data.
            result_d   = mac_conv_valid ? mac_conv_out : '0;
            win_hold_d = window_q;
            wgt_hold_d = wgt_rd_data;
            state_d    = OUT;
         end
         OUT: begin
            if (result_ready) begin
               if (w_is_last) begin
                  oc_d    = '0;
                  state_d = IDLE;
               end else begin
                  oc_d    = oc_q + 1'b1;
                  state_d = FETCH;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         oc_q       <= '0;
         window_q   <= '0;
         result_q   <= '0;
         win_hold_q <= '0;
         wgt_hold_q <= '0;
      end else begin
         state_q    <= state_d;
         oc_q       <= oc_d;
         window_q   <= window_d;
         result_q   <= result_d;
         win_hold_q <= win_hold_d;
         wgt_hold_q <= wgt_hold_d;
      end
   end

   assign window_ready     = (state_q == IDLE);
   assign wgt_rd_en        = (state_q == FETCH);
   assign wgt_addr         = oc_q;
   assign mac_window_valid = (state_q == MAC);
   assign mac_weight_valid = (state_q == MAC);
   // Outside MAC the drive holds what the MAC last saw.
   assign mac_window       = (state_q == MAC) ? window_q    : win_hold_q;
   assign mac_weight       = (state_q == MAC) ? wgt_rd_data : wgt_hold_q;
   assign result_data      = result_q;
   assign result_oc        = oc_q;
   assign result_valid     = (state_q == OUT);
   assign result_last      = (state_q == OUT) && w_is_last;

`ifdef CONV_OC_PERF_CNT_EN
   logic [31:0] perf_busy_q, perf_busy_d;
   logic [31:0] perf_res_q, perf_res_d;

   always_comb begin
      perf_busy_d = perf_busy_q + ((state_q != IDLE) ? 32'd1 : 32'd0);
      perf_res_d  = perf_res_q + (w_out_hs ? 32'd1 : 32'd0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_busy_q <= '0;
         perf_res_q  <= '0;
      end else begin
         perf_busy_q <= perf_busy_d;
         perf_res_q  <= perf_res_d;
      end
   end

   assign perf_busy_cycles = perf_busy_q;
   assign perf_results     = perf_res_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_conv_oc_scheduler.sv
// ============================================================================
// tb_conv_oc_scheduler -- scoreboard bench for conv_oc_scheduler with RAM and saturating MAC models
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_conv_oc_scheduler;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          window_valid;
   logic          window_ready;
   logic [215:0]  win_in;
   logic          wgt_rd_en;
   logic [1:0]    wgt_addr;
   logic [215:0]  wgt_rd_data = '0;
   logic [215:0]  mac_window;
   logic          mac_window_valid;
   logic [215:0]  mac_weight;
   logic          mac_weight_valid;
   logic [19:0]   mac_conv_out;
   logic          mac_conv_valid;
   logic [19:0]   result_data;
   logic [1:0]    result_oc;
   logic          result_last;
   logic          result_valid;
   logic          result_ready;
   logic          mac_force_bad;
   logic [7:0]    wval [4];
`ifdef CONV_OC_PERF_CNT_EN
   logic [31:0]   perf_busy_cycles;
   logic [31:0]   perf_results;
`endif

   conv_oc_scheduler dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .window_valid            (window_valid),
      .window_ready            (window_ready),
      .multi_channel_window_in (win_in),
      .wgt_rd_en               (wgt_rd_en),
      .wgt_addr                (wgt_addr),
      .wgt_rd_data             (wgt_rd_data),
      .mac_window              (mac_window),
      .mac_window_valid        (mac_window_valid),
      .mac_weight              (mac_weight),
      .mac_weight_valid        (mac_weight_valid),
      .mac_conv_out            (mac_conv_out),
      .mac_conv_valid          (mac_conv_valid),
      .result_data             (result_data),
      .result_oc               (result_oc),
      .result_last             (result_last),
      .result_valid            (result_valid),
      .result_ready            (result_ready)
`ifdef CONV_OC_PERF_CNT_EN
      ,
      .perf_busy_cycles        (perf_busy_cycles),
      .perf_results            (perf_results)
`endif
   );

   always #5 clk = ~clk;

   // Saturating combinational MAC standing in for the parent-level mult_acc_comb.
   function automatic logic [19:0] mac_sat(input logic [215:0] w, input logic [215:0] g);
      longint acc;
      acc = 0;
      for (int i = 0; i < 27; i++)
         acc += longint'(w[i*8 +: 8]) * longint'(g[i*8 +: 8]);
      return (acc > 64'd1048575) ? 20'hFFFFF : acc[19:0];
   endfunction

   always_comb begin
      mac_conv_out   = mac_sat(mac_window, mac_weight);
      mac_conv_valid = mac_window_valid && mac_weight_valid && !mac_force_bad;
   end

   // Weight RAM: one-cycle read latency, filler pattern when not reading.
   always @(posedge clk) begin
      if (wgt_rd_en) wgt_rd_data <= {27{wval[wgt_addr]}};
      else           wgt_rd_data <= {27{8'hA5}};
   end

   typedef struct packed {
      logic [19:0] data;
      logic [1:0]  oc;
      logic        last;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   ref_cyc = 0;
   int   acc_cyc = 0;
   int   last_hs_cyc = 0;
   bit   busy = 1'b0;
   bit   hold_active = 1'b0;
   logic [19:0] hold_data;
   logic [1:0]  hold_oc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   always @(posedge clk) cyc++;

   // Monitor: compares every result handshake against the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         busy        = 1'b0;
         hold_active = 1'b0;
      end else begin
         if (busy) check("window_ready_low", {31'd0, window_ready}, 32'd0);
         if (hold_active) begin
            check("stall_data", {12'd0, result_data}, {12'd0, hold_data});
            check("stall_oc", {30'd0, result_oc}, {30'd0, hold_oc});
            check("stall_rd_en", {31'd0, wgt_rd_en}, 32'd0);
         end
         if (window_valid && window_ready) begin
            acc_cyc = cyc;
            ref_cyc = cyc;
            busy    = 1'b1;
         end
         if (result_valid) begin
            if (!hold_active) check("result_latency", cyc - ref_cyc, 32'd3);
            if (result_ready) begin
               hold_active = 1'b0;
               ref_cyc     = cyc;
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_result actual=%0d required=none", result_data);
               end else begin
                  e = exp_q.pop_front();
                  check("result_data", {12'd0, result_data}, {12'd0, e.data});
                  check("result_oc", {30'd0, result_oc}, {30'd0, e.oc});
                  check("result_last", {31'd0, result_last}, {31'd0, e.last});
               end
               if (result_last) begin
                  busy        = 1'b0;
                  last_hs_cyc = cyc;
               end
            end else begin
               hold_active = 1'b1;
               hold_data   = result_data;
               hold_oc     = result_oc;
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push4(input logic [19:0] d0, input logic [19:0] d1,
                        input logic [19:0] d2, input logic [19:0] d3);
      exp_q.push_back('{data: d0, oc: 2'd0, last: 1'b0});
      exp_q.push_back('{data: d1, oc: 2'd1, last: 1'b0});
      exp_q.push_back('{data: d2, oc: 2'd2, last: 1'b0});
      exp_q.push_back('{data: d3, oc: 2'd3, last: 1'b1});
   endtask

   task automatic send_window(input logic [7:0] v);
      int n = 0;
      win_in       = {27{v}};
      window_valid = 1'b1;
      while (!window_ready && n < 50) begin tick; n++; end
      if (n >= 50) check("accept_timeout", 32'd1, 32'd0);
      tick;
      window_valid = 1'b0;
   endtask

   task automatic wait_res_oc(input logic [1:0] oc);
      int n = 0;
      while (!(result_valid && result_oc == oc) && n < 100) begin tick; n++; end
      if (n >= 100) check("wait_result_timeout", 32'd1, 32'd0);
   endtask

   task automatic drain;
      int n = 0;
      while ((exp_q.size() != 0 || !window_ready) && n < 200) begin tick; n++; end
      check("drain_queue_empty", exp_q.size(), 32'd0);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_window_ready"}, {31'd0, window_ready}, 32'd1);
      check({tag, "_result_valid"}, {31'd0, result_valid}, 32'd0);
      check({tag, "_result_data"}, {12'd0, result_data}, 32'd0);
      check({tag, "_result_oc"}, {30'd0, result_oc}, 32'd0);
      check({tag, "_result_last"}, {31'd0, result_last}, 32'd0);
      check({tag, "_wgt_rd_en"}, {31'd0, wgt_rd_en}, 32'd0);
      check({tag, "_mac_valids"}, {30'd0, mac_window_valid, mac_weight_valid}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "global timeout");
   end

   initial begin
      int n;
      rst_n         = 1'b0;
      window_valid  = 1'b0;
      win_in        = '0;
      result_ready  = 1'b1;
      mac_force_bad = 1'b0;
      wval[0] = 8'd1; wval[1] = 8'd2; wval[2] = 8'd3; wval[3] = 8'd4;
      repeat (3) tick;
      check_idle_outputs("reset");
      rst_n = 1'b1;
      tick;

      // Basic window plus a 5-cycle stall on oc=1.
      push4(20'd27, 20'd54, 20'd81, 20'd108);
      send_window(8'd1);
      wait_res_oc(2'd1);
      result_ready = 1'b0;
      repeat (5) tick;
      check("stall_value_54", {12'd0, result_data}, 32'd54);
      result_ready = 1'b1;
      drain;

      // Saturation.
      wval[0] = 8'hFF; wval[1] = 8'hFF; wval[2] = 8'hFF; wval[3] = 8'hFF;
      push4(20'd1048575, 20'd1048575, 20'd1048575, 20'd1048575);
      send_window(8'hFF);
      drain;
      wval[0] = 8'd1; wval[1] = 8'd2; wval[2] = 8'd3; wval[3] = 8'd4;

      // MAC return flagged invalid -> zero captured.
      mac_force_bad = 1'b1;
      push4(20'd0, 20'd0, 20'd0, 20'd0);
      send_window(8'd1);
      drain;
      mac_force_bad = 1'b0;

      // window_valid held high across a whole window.
      push4(20'd27, 20'd54, 20'd81, 20'd108);
      push4(20'd54, 20'd108, 20'd162, 20'd216);
      send_window(8'd1);
      win_in       = {27{8'd2}};
      window_valid = 1'b1;
      n = 0;
      while (!window_ready && n < 100) begin tick; n++; end
      tick;
      window_valid = 1'b0;
      check("reaccept_gap", acc_cyc - last_hs_cyc, 32'd1);
      drain;

      // Reset while presenting oc=2.
      exp_q.push_back('{data: 20'd27, oc: 2'd0, last: 1'b0});
      exp_q.push_back('{data: 20'd54, oc: 2'd1, last: 1'b0});
      send_window(8'd1);
      wait_res_oc(2'd2);
      result_ready = 1'b0;
      tick;
      rst_n = 1'b0;
      tick;
      check_idle_outputs("midreset");
      rst_n        = 1'b1;
      result_ready = 1'b1;
      repeat (10) tick;
      check("no_result_after_reset", exp_q.size(), 32'd0);
      push4(20'd27, 20'd54, 20'd81, 20'd108);
      send_window(8'd1);
      drain;
`ifdef CONV_OC_PERF_CNT_EN
      check("perf_results", perf_results, 32'd4);
      check("perf_busy_cycles", perf_busy_cycles, 32'd12);
`endif

      repeat (3) tick;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
